// File: rtl/conv1d_seq_engine_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the sequential 1-D convolution engine:
//   conv_state_t : control FSM states (IDLE, COMPUTE, DONE)
//   conv_accw()  : full-precision output width for DW-bit operands, TAPS terms
//   conv_nout()  : number of outputs of a full linear convolution
// ---------------------------------------------------------------------------
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } conv_state_t;

  // Width that holds a sum of TAPS products of two DW-bit values.
  function automatic int conv_accw(input int dw, input int taps);
    return 2 * dw + $clog2(taps);
  endfunction

  // Length of the full linear convolution of two TAPS-long vectors.
  function automatic int conv_nout(input int taps);
    return 2 * taps - 1;
  endfunction

endpackage

// File: rtl/conv1d_seq_engine_dot_row.sv
// ---------------------------------------------------------------------------
// conv_dot_row
// Combinational evaluation of one convolution output:
//   y[k] = sum over i of x[i]*h[k-i], terms with k-i outside [0,TAPS) are 0.
// Optional build macro: CONV_SIGNED_EN (two's-complement operands when
// defined, unsigned operands otherwise).
// Ports:
//   i_x_vec [TAPS*DW] : registered x operands, x[0] at LSB
//   i_h_vec [TAPS*DW] : registered h operands, h[0] at LSB
//   i_k     [KW]      : output index, 0..NOUT-1
//   o_y     [ACCW]    : y[k]
// ---------------------------------------------------------------------------
module conv_dot_row
  import conv_pkg::*;
#(
  parameter int DW   = 4,
  parameter int TAPS = 4,
  parameter int ACCW = conv_accw(DW, TAPS),
  parameter int KW   = $clog2(conv_nout(TAPS))
) (
  input  logic [TAPS*DW-1:0] i_x_vec,
  input  logic [TAPS*DW-1:0] i_h_vec,
  input  logic [KW-1:0]      i_k,
  output logic [ACCW-1:0]    o_y
);

  localparam int HIW = $clog2(TAPS);

  logic [DW-1:0]   w_h_arr [TAPS];
  logic [ACCW-1:0] w_terms [TAPS];
  logic [ACCW-1:0] w_sum;

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_h_unpack
    assign w_h_arr[gi] = i_h_vec[gi*DW +: DW];
  end

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    logic [KW:0]     w_j;
    logic            w_in_range;
    logic [DW-1:0]   w_x;
    logic [DW-1:0]   w_h;

    // j = k - i; the extra MSB keeps the comparison honest when k < i
    assign w_j        = {1'b0, i_k} - (KW+1)'(gi);
    assign w_in_range = ({1'b0, i_k} >= (KW+1)'(gi)) && (w_j < (KW+1)'(TAPS));
    assign w_x        = i_x_vec[gi*DW +: DW];
    // only the low bits index h; out-of-range picks are masked below
    assign w_h        = w_h_arr[w_j[HIW-1:0]];

`ifdef CONV_SIGNED_EN
    logic signed [2*DW-1:0] w_prod;
    assign w_prod = $signed({{DW{w_x[DW-1]}}, w_x}) * $signed({{DW{w_h[DW-1]}}, w_h});
    // signed cast sign-extends the product up to ACCW
    assign w_terms[gi] = w_in_range ? ACCW'(w_prod) : {ACCW{1'b0}};
`else
    logic [2*DW-1:0] w_prod;
    assign w_prod = {{DW{1'b0}}, w_x} * {{DW{1'b0}}, w_h};
    assign w_terms[gi] = w_in_range ? ACCW'(w_prod) : {ACCW{1'b0}};
`endif
  end

  // Accumulate the masked products at full ACCW width
  always_comb begin
    w_sum = {ACCW{1'b0}};
    for (int i = 0; i < TAPS; i++) begin
      w_sum = w_sum + w_terms[i];
    end
  end

  assign o_y = w_sum;

endmodule

// File: rtl/conv1d_seq_engine.sv
// ---------------------------------------------------------------------------
// conv1d_seq_engine
// Sequential full linear convolution of x (TAPS samples) with h (TAPS taps),
// one output per cycle, result handed over on a valid/ready handshake.
// Optional build macro: CONV_SIGNED_EN (two's-complement arithmetic).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : request handshake (ready only in IDLE)
//   x_vec, h_vec         : operands, element 0 at LSB
//   out_valid / out_ready: result handshake (valid only in DONE)
//   y_vec                : packed results, y[k] at k*ACCW
//   busy                 : high while computing or holding a result
// ---------------------------------------------------------------------------
module conv1d_seq_engine
  import conv_pkg::*;
#(
  parameter int DW   = 4,
  parameter int TAPS = 4,
  parameter int ACCW = conv_accw(DW, TAPS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [TAPS*DW-1:0]                 x_vec,
  input  logic [TAPS*DW-1:0]                 h_vec,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [conv_nout(TAPS)*ACCW-1:0]    y_vec,
  output logic                               busy
);

  localparam int NOUT = conv_nout(TAPS);
  localparam int KW   = $clog2(NOUT);
  localparam logic [KW-1:0] K_LAST = KW'(NOUT - 1);

  conv_state_t         r_state;
  conv_state_t         w_next_state;
  logic [KW-1:0]       r_k;
  logic [TAPS*DW-1:0]  r_x;
  logic [TAPS*DW-1:0]  r_h;
  logic [ACCW-1:0]     r_y [NOUT];
  logic [ACCW-1:0]     w_row;
  logic                w_accept;
  logic                w_write;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;

  conv_dot_row #(
    .DW   (DW),
    .TAPS (TAPS),
    .ACCW (ACCW),
    .KW   (KW)
  ) u_dot_row (
    .i_x_vec (r_x),
    .i_h_vec (r_h),
    .i_k     (r_k),
    .o_y     (w_row)
  );

  // Next-state and datapath strobes
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_write      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = COMPUTE;
        end else begin
          w_next_state = IDLE;
        end
      end
      COMPUTE: begin
        w_write = 1'b1;
        if (r_k == K_LAST) begin
          w_next_state = DONE;
        end else begin
          w_next_state = COMPUTE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register plus handshake flags decoded from the next state,
  // so the outputs come straight from flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state == IDLE);
      r_out_valid <= (w_next_state == DONE);
      r_busy      <= (w_next_state != IDLE);
    end
  end

  // Operand capture and output index; k parks at its last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= {(TAPS*DW){1'b0}};
      r_h <= {(TAPS*DW){1'b0}};
      r_k <= {KW{1'b0}};
    end else if (w_accept) begin
      r_x <= x_vec;
      r_h <= h_vec;
      r_k <= {KW{1'b0}};
    end else if (w_write && (r_k != K_LAST)) begin
      r_k <= r_k + {{(KW-1){1'b0}}, 1'b1};
    end
  end

  // Result register file; only the addressed entry changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NOUT; i++) begin
        r_y[i] <= {ACCW{1'b0}};
      end
    end else if (w_write) begin
      r_y[r_k] <= w_row;
    end
  end

  for (genvar gk = 0; gk < NOUT; gk++) begin : g_pack
    assign y_vec[gk*ACCW +: ACCW] = r_y[gk];
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_conv1d_seq_engine.sv
// ---------------------------------------------------------------------------
// tb_conv1d_seq_engine
// Self-checking bench: directed cases plus random operands, each compared
// with a plain-arithmetic convolution model.
// ---------------------------------------------------------------------------
module tb_conv1d_seq_engine;

  localparam int DW   = 4;
  localparam int TAPS = 4;
  localparam int ACCW = 2 * DW + $clog2(TAPS);
  localparam int NOUT = 2 * TAPS - 1;
  localparam int YW   = NOUT * ACCW;
  localparam int LAT  = NOUT;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [TAPS*DW-1:0] x_vec;
  logic [TAPS*DW-1:0] h_vec;
  logic               out_valid;
  logic               out_ready;
  logic [YW-1:0]      y_vec;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  conv1d_seq_engine #(
    .DW   (DW),
    .TAPS (TAPS),
    .ACCW (ACCW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_vec     (x_vec),
    .h_vec     (h_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_vec     (y_vec),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int elem(input logic [TAPS*DW-1:0] v, input int i);
    logic [DW-1:0] e;
    e = v[i*DW +: DW];
`ifdef CONV_SIGNED_EN
    return int'($signed(e));
`else
    return int'(e);
`endif
  endfunction

  // Reference: textbook convolution sum, truncated to ACCW per output
  function automatic logic [YW-1:0] conv_model(input logic [TAPS*DW-1:0] xv, input logic [TAPS*DW-1:0] hv);
    logic [YW-1:0]   r;
    logic [ACCW-1:0] t;
    int              s;
    r = '0;
    for (int k = 0; k < NOUT; k++) begin
      s = 0;
      for (int i = 0; i < TAPS; i++) begin
        if (k - i >= 0 && k - i < TAPS) s += elem(xv, i) * elem(hv, k - i);
      end
      t = ACCW'(s);
      r[k*ACCW +: ACCW] = t;
    end
    return r;
  endfunction

  function automatic logic [YW-1:0] pack_y(input int ys [NOUT]);
    logic [YW-1:0]   r;
    logic [ACCW-1:0] t;
    r = '0;
    for (int k = 0; k < NOUT; k++) begin
      t = ACCW'(ys[k]);
      r[k*ACCW +: ACCW] = t;
    end
    return r;
  endfunction

  function automatic logic [TAPS*DW-1:0] pack_v(input int a0, input int a1, input int a2, input int a3);
    logic [TAPS*DW-1:0] r;
    r = {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_in_ready"}, 128'(in_ready), 128'(1'b1));
    check_val({tag, "_out_valid"}, 128'(out_valid), 128'(1'b0));
    check_val({tag, "_busy"}, 128'(busy), 128'(1'b0));
    check_val({tag, "_y_vec"}, 128'(y_vec), 128'(0));
  endtask

  // One full transaction; stall>0 holds out_ready low in DONE for that many
  // cycles while firing ignored requests
  task automatic run_op(input string tag, input logic [TAPS*DW-1:0] xv, input logic [TAPS*DW-1:0] hv,
                        input logic [YW-1:0] exp_y, input int stall);
    int cyc;
    check_val({tag, "_ready_before"}, 128'(in_ready), 128'(1'b1));
    x_vec     = xv;
    h_vec     = hv;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    x_vec    = TAPS*DW'($urandom);
    h_vec    = TAPS*DW'($urandom);
    check_val({tag, "_busy_after_accept"}, 128'(busy), 128'(1'b1));
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      if (cyc == 2) begin
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check_val({tag, "_latency"}, 128'(cyc), 128'(LAT));
    check_val({tag, "_y"}, 128'(y_vec), 128'(exp_y));
    check_val({tag, "_ready_in_done"}, 128'(in_ready), 128'(1'b0));
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom);
      x_vec    = TAPS*DW'($urandom);
      h_vec    = TAPS*DW'($urandom);
      tick();
      check_val({tag, "_stall_valid"}, 128'(out_valid), 128'(1'b1));
      check_val({tag, "_stall_y"}, 128'(y_vec), 128'(exp_y));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val({tag, "_idle_valid"}, 128'(out_valid), 128'(1'b0));
    check_val({tag, "_idle_ready"}, 128'(in_ready), 128'(1'b1));
    check_val({tag, "_idle_busy"}, 128'(busy), 128'(1'b0));
  endtask

  initial begin
    int ys [NOUT];
    logic [TAPS*DW-1:0] xr;
    logic [TAPS*DW-1:0] hr;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_vec     = '0;
    h_vec     = '0;
    #12;
    check_reset_state("reset");
    rst = 1'b0;
    tick();
    check_reset_state("post_reset");

    // small positive sum, identical in both builds
    ys = '{1, 3, 6, 10, 9, 7, 4};
    run_op("sum", pack_v(1, 2, 3, 4), pack_v(1, 1, 1, 1), pack_y(ys), 0);

    // all-ones nibbles: maximum unsigned, or -1 everywhere when signed
`ifdef CONV_SIGNED_EN
    ys = '{1, 2, 3, 4, 3, 2, 1};
`else
    ys = '{225, 450, 675, 900, 675, 450, 225};
`endif
    run_op("max", pack_v(15, 15, 15, 15), pack_v(15, 15, 15, 15), pack_y(ys), 0);

    // back-pressure with ignored requests
    xr = pack_v(3, 7, 1, 9);
    hr = pack_v(2, 5, 4, 6);
    run_op("stall", xr, hr, conv_model(xr, hr), 20);

    // reset while computing at k=3
    x_vec    = pack_v(5, 6, 7, 3);
    h_vec    = pack_v(4, 3, 2, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_reset_state("midreset");
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_val("midreset_no_valid", 128'(out_valid), 128'(1'b0));
    end
    ys = '{6, 2, 0, 0, 0, 0, 0};
    run_op("after_reset", pack_v(2, 0, 0, 0), pack_v(3, 1, 0, 0), pack_y(ys), 0);

    // reset while holding a result
    x_vec    = pack_v(1, 1, 1, 1);
    h_vec    = pack_v(1, 1, 1, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < NOUT + 1; c++) tick();
    check_val("done_hold_valid", 128'(out_valid), 128'(1'b1));
    rst = 1'b1;
    #1;
    check_reset_state("donereset");
    tick();
    rst = 1'b0;
    tick();

    // random operands against the model
    for (int n = 0; n < 12; n++) begin
      xr = TAPS*DW'($urandom);
      hr = TAPS*DW'($urandom);
      run_op("rand", xr, hr, conv_model(xr, hr), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv1d_seq_engine.md
Name: conv1d_seq_engine

Overview:
Parametrised, sequential successor to the packed 4-tap convolution unit used by the RISC-V custom-instruction path. It computes the full linear convolution of a TAPS-sample input vector x with a TAPS-coefficient kernel h. Each output is computed at full precision, with no per-output truncation. It produces one output sample per cycle and hands the packed result vector to the core through a valid/ready handshake.

Parameters:
DW, 4, bit width of each x and h element
TAPS, 4, number of elements in x and in h (≥2)
ACCW, 2*DW+$clog2(TAPS), width of each output element y[k]; the default guarantees no overflow
NOUT, 2*TAPS-1, number of outputs (derived; not overridable)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  request carries valid operands
in_ready  output  1  engine can accept a request; high only in IDLE
x_vec  input  TAPS*DW  x[i] = x_vec[i*DW +: DW], x[0] at LSB
h_vec  input  TAPS*DW  h[i] = h_vec[i*DW +: DW]
out_valid  output  1  y_vec holds a complete result
out_ready  input  1  consumer accepts the result
y_vec  output  NOUT*ACCW  y[k] = y_vec[k*ACCW +: ACCW]
busy  output  1  high in COMPUTE or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, k=0, in_ready=1, out_valid=0, busy=0, y_vec=0, operand registers=0.
- Arithmetic: y[k] = Σ x[i]*h[k-i] over all i with 0≤i<TAPS and 0≤k-i<TAPS.
  - Products are DW×DW→2*DW bits.
  - Sums are formed at ACCW bits.
  - Out-of-range terms contribute 0.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register x_vec and h_vec, set k=0, go to COMPUTE.
  - in_valid low: stay in IDLE.
- COMPUTE:
  - in_ready=0.
  - Each cycle writes y[k] from the registered operands and increments k.
  - At the edge that writes y[NOUT-1], go to DONE.
  - The other y entries keep their old values until overwritten.
- DONE:
  - out_valid=1, in_ready=0.
  - y_vec is stable until out_valid&&out_ready; on that handshake go to IDLE with out_valid=0.
  - out_ready held low stalls indefinitely with y_vec unchanged.
- Latency: out_valid rises NOUT cycles after the accepting edge (7 cycles at TAPS=4).
  - Minimum spacing between accepted requests is NOUT+2 cycles.
  - A new request cannot be accepted in the same cycle the result is accepted.
- Boundary conditions:
  - in_valid asserted while busy is ignored; operands are not captured.
  - out_ready asserted outside DONE has no effect.
  - Changes on x_vec or h_vec after the accepting edge do not affect the result.
  - rst asserted mid-COMPUTE or in DONE returns all state to reset values immediately. The partial result is discarded and no out_valid is generated.
  - k never exceeds NOUT-1; it resets to 0 on each acceptance.

Optional Feature:
CONV_SIGNED_EN:
- Defined: x and h elements are two's complement. Products are signed and sign-extended to ACCW before summation; y[k] is a two's-complement ACCW-bit value.
- Undefined: all elements are unsigned and zero-extended.
- Handshake and timing are identical in both builds.

Decomposition:
- Package conv_pkg:
  - FSM state enum conv_state_t (IDLE, COMPUTE, DONE).
  - Function conv_accw(dw, taps) returning 2*dw+$clog2(taps).
  - Function conv_nout(taps) returning 2*taps-1.
- Sub-module conv_dot_row (combinational): given the registered x, h and index k, produce y[k]. It uses TAPS multipliers with range masking and an adder tree. The top level holds the FSM, counter, operand registers and result register file.

Test Plan:
1. Reset → in_ready=1, out_valid=0, busy=0, y_vec=0.
2. Unsigned sum: TAPS=4, x={1,2,3,4}, h={1,1,1,1}, out_ready=1 → out_valid exactly 7 cycles after accept; y={1,3,6,10,9,7,4}; then IDLE.
3. Unsigned maximum: x=h={15,15,15,15}, unsigned build → y={225,450,675,900,675,450,225}, no overflow in ACCW=10.
4. Signed build (CONV_SIGNED_EN): x=h all 4'hF → y={1,2,3,4,3,2,1}.
   - Same stimulus in the unsigned build must give item 3's values.
5. Back-pressure and ignored requests:
   - Hold out_ready=0 for 20 cycles → out_valid and y_vec stable throughout.
   - Toggle in_valid with new operands during that window → not accepted, result unchanged.
   - Raise out_ready → IDLE one cycle later.
6. Reset mid-compute: assert rst at k=3 → outputs return to reset values immediately with no out_valid pulse. A following request x={2,0,0,0}, h={3,1,0,0} → y={6,2,0,0,0,0,0}.
